// File: rtl/ram_burst_controller.sv
// Clocked MAR-addressed RAM with burst reads/writes, MAR auto-increment/wrap
// and a configurable read pipeline latency behind a busy/valid handshake.
module ram_burst_controller #(
    parameter int SIZE         = 16,
    parameter int MAR_SIZE     = 8,
    parameter int READ_LATENCY = 1,
    parameter int BL_W         = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [MAR_SIZE-1:0] address,
    input  logic                set_address,
    input  logic                set,
    input  logic                enable,
    input  logic [BL_W-1:0]     burst_len,
    input  logic [SIZE-1:0]     data_in,
    input  logic                data_in_valid,
    output logic [SIZE-1:0]     data_out,
    output logic                data_out_valid,
    output logic                busy,
    output logic                err,
    output logic [MAR_SIZE-1:0] mar_out
);

    localparam int DEPTH = 2 ** MAR_SIZE;
    localparam int BW    = BL_W + 1;
    localparam int DCW   = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;

    localparam logic [MAR_SIZE-1:0] MAR_ONE    = MAR_SIZE'(1'b1);
    localparam logic [BW-1:0]       BEATS_ONE  = BW'(1'b1);
    localparam logic [DCW-1:0]      DRAIN_ONE  = DCW'(1'b1);
    localparam logic [DCW-1:0]      DRAIN_INIT = DCW'((READ_LATENCY > 1) ? (READ_LATENCY - 2) : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t              state_q;
    logic [MAR_SIZE-1:0] mar_q;
    logic [MAR_SIZE-1:0] mar_d;
    logic [BW-1:0]       beats_q;
    logic [DCW-1:0]      drain_q;
    logic [SIZE-1:0]     data_out_q;
    logic                data_out_valid_q;
    logic                busy_q;
    logic                err_q;
    logic [SIZE-1:0]     mem_q [0:DEPTH-1];

    logic                issue_s;
    logic                wr_en_s;
    logic                last_beat_s;
    logic [BW-1:0]       beats_init_s;
    logic [MAR_SIZE-1:0] mar_inc_s;
    logic [SIZE-1:0]     rd_data_s;
    logic                out_vld_s;
    logic [SIZE-1:0]     out_data_s;

    assign issue_s      = (state_q == ST_READ);
    assign wr_en_s      = (state_q == ST_WRITE) && data_in_valid;
    assign last_beat_s  = (beats_q == BEATS_ONE);
    assign beats_init_s = {1'b0, burst_len} + BEATS_ONE;
    assign mar_inc_s    = mar_q + MAR_ONE;
    assign rd_data_s    = mem_q[mar_q];

    // Next MAR: load in IDLE, advance once per committed write or read issue.
    always_comb begin
        mar_d = mar_q;
        case (state_q)
            ST_IDLE: begin
                if (set_address) mar_d = address;
                else             mar_d = mar_q;
            end
            ST_WRITE: begin
                if (data_in_valid) mar_d = mar_inc_s;
                else               mar_d = mar_q;
            end
            ST_READ:  mar_d = mar_inc_s;
            ST_DRAIN: mar_d = mar_q;
            default:  mar_d = mar_q;
        endcase
    end

    // Control FSM with registered busy/err and burst bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mar_q   <= '0;
            beats_q <= '0;
            drain_q <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            mar_q <= mar_d;
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (set && enable) begin
                        err_q <= 1'b1;
                    end else if (set) begin
                        beats_q <= beats_init_s;
                        state_q <= ST_WRITE;
                        busy_q  <= 1'b1;
                    end else if (enable) begin
                        beats_q <= beats_init_s;
                        state_q <= ST_READ;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    if (data_in_valid) begin
                        beats_q <= beats_q - BEATS_ONE;
                        if (last_beat_s) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                ST_READ: begin
                    beats_q <= beats_q - BEATS_ONE;
                    if (last_beat_s) begin
                        // With single-edge latency the last issue already presents its data.
                        if (READ_LATENCY == 1) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_DRAIN;
                            drain_q <= DRAIN_INIT;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == '0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        drain_q <= drain_q - DRAIN_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Memory array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) mem_q[mar_q] <= data_in;
    end

    generate
        if (READ_LATENCY <= 1) begin : g_lat1
            assign out_vld_s  = issue_s;
            assign out_data_s = rd_data_s;
        end else begin : g_latn
            logic [READ_LATENCY-2:0] pv_q;
            logic [SIZE-1:0]         pd_q [0:READ_LATENCY-2];

            // Read pipeline: stage 0 captures at the issue edge, the final stage feeds data_out.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pv_q <= '0;
                    for (int i = 0; i < READ_LATENCY - 1; i++) pd_q[i] <= '0;
                end else begin
                    pv_q[0] <= issue_s;
                    pd_q[0] <= rd_data_s;
                    for (int i = 1; i < READ_LATENCY - 1; i++) begin
                        pv_q[i] <= pv_q[i-1];
                        pd_q[i] <= pd_q[i-1];
                    end
                end
            end

            assign out_vld_s  = pv_q[READ_LATENCY-2];
            assign out_data_s = pd_q[READ_LATENCY-2];
        end
    endgenerate

    // Output data register holds its last value between valid beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
        end else begin
            data_out_valid_q <= out_vld_s;
            if (out_vld_s) data_out_q <= out_data_s;
        end
    end

    assign data_out       = data_out_q;
    assign data_out_valid = data_out_valid_q;
    assign busy           = busy_q;
    assign err            = err_q;
    assign mar_out        = mar_q;

endmodule

// File: tb/tb_ram_burst_controller.sv
// Directed bench for ram_burst_controller: one instance at latency 1, one at latency 3.
module tb_ram_burst_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [7:0]  address;
    logic        set_address, set, enable, data_in_valid;
    logic [2:0]  burst_len;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        data_out_valid, busy, err;
    logic [7:0]  mar_out;

    logic [7:0]  b_address;
    logic        b_set_address, b_set, b_enable, b_data_in_valid;
    logic [2:0]  b_burst_len;
    logic [15:0] b_data_in;
    logic [15:0] b_data_out;
    logic        b_data_out_valid, b_busy, b_err;
    logic [7:0]  b_mar_out;

    int cmp_cnt = 0;
    int err_cnt = 0;

    ram_burst_controller #(.SIZE(16), .MAR_SIZE(8), .READ_LATENCY(1), .BL_W(3)) dut (
        .clk(clk), .rst(rst), .address(address), .set_address(set_address),
        .set(set), .enable(enable), .burst_len(burst_len), .data_in(data_in),
        .data_in_valid(data_in_valid), .data_out(data_out), .data_out_valid(data_out_valid),
        .busy(busy), .err(err), .mar_out(mar_out)
    );

    ram_burst_controller #(.SIZE(16), .MAR_SIZE(8), .READ_LATENCY(3), .BL_W(3)) dut3 (
        .clk(clk), .rst(rst), .address(b_address), .set_address(b_set_address),
        .set(b_set), .enable(b_enable), .burst_len(b_burst_len), .data_in(b_data_in),
        .data_in_valid(b_data_in_valid), .data_out(b_data_out), .data_out_valid(b_data_out_valid),
        .busy(b_busy), .err(b_err), .mar_out(b_mar_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cmds();
        set_address = 1'b0; set = 1'b0; enable = 1'b0; data_in_valid = 1'b0;
        b_set_address = 1'b0; b_set = 1'b0; b_enable = 1'b0; b_data_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        address = 8'h00; burst_len = 3'd0; data_in = 16'h0000; b_address = 8'h00;
        b_burst_len = 3'd0; b_data_in = 16'h0000;
        idle_cmds();
        rst = 1'b1;
        tick(); tick();
        cmp_cnt++; if (data_out !== 16'h0000) begin err_cnt++; $display("FAIL rst_data_out: got %h want 0000", data_out); end
        cmp_cnt++; if (data_out_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_valid: got %b want 0", data_out_valid); end
        cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rst_busy: got %b want 0", busy); end
        cmp_cnt++; if (err !== 1'b0) begin err_cnt++; $display("FAIL rst_err: got %b want 0", err); end
        cmp_cnt++; if (mar_out !== 8'h00) begin err_cnt++; $display("FAIL rst_mar: got %h want 00", mar_out); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_beat();
        address = 8'h00; set_address = 1'b1; set = 1'b1; burst_len = 3'd0;
        tick();
        cmp_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL sb_wr_busy: got %b want 1", busy); end
        idle_cmds();
        data_in = 16'hABCD; data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
        cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL sb_wr_done: got %b want 0", busy); end
        cmp_cnt++; if (mar_out !== 8'h01) begin err_cnt++; $display("FAIL sb_wr_mar: got %h want 01", mar_out); end
        address = 8'h00; set_address = 1'b1; enable = 1'b1; burst_len = 3'd0;
        tick();
        idle_cmds();
        cmp_cnt++; if (data_out_valid !== 1'b0) begin err_cnt++; $display("FAIL sb_rd_early: got %b want 0", data_out_valid); end
        tick();
        cmp_cnt++; if (data_out !== 16'hABCD) begin err_cnt++; $display("FAIL sb_rd_data: got %h want abcd", data_out); end
        cmp_cnt++; if (data_out_valid !== 1'b1) begin err_cnt++; $display("FAIL sb_rd_valid: got %b want 1", data_out_valid); end
        cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL sb_rd_busy: got %b want 0", busy); end
        cmp_cnt++; if (mar_out !== 8'h01) begin err_cnt++; $display("FAIL sb_rd_mar: got %h want 01", mar_out); end
        tick();
        cmp_cnt++; if (data_out_valid !== 1'b0) begin err_cnt++; $display("FAIL sb_strobe: got %b want 0", data_out_valid); end
        cmp_cnt++; if (data_out !== 16'hABCD) begin err_cnt++; $display("FAIL sb_hold: got %h want abcd", data_out); end
    endtask

    task automatic test_wrap();
        logic [15:0] wdat [4];
        wdat[0] = 16'h1111; wdat[1] = 16'h2222; wdat[2] = 16'h3333; wdat[3] = 16'h4444;
        address = 8'hFE; set_address = 1'b1; set = 1'b1; burst_len = 3'd3;
        tick();
        idle_cmds();
        for (int i = 0; i < 4; i++) begin
            data_in = wdat[i]; data_in_valid = 1'b1;
            tick();
            if (i == 2) begin
                cmp_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL wrap_wr_busy: got %b want 1", busy); end
            end
        end
        data_in_valid = 1'b0;
        cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL wrap_wr_done: got %b want 0", busy); end
        cmp_cnt++; if (mar_out !== 8'h02) begin err_cnt++; $display("FAIL wrap_wr_mar: got %h want 02", mar_out); end
        address = 8'hFE; set_address = 1'b1; enable = 1'b1; burst_len = 3'd3;
        tick();
        idle_cmds();
        for (int i = 0; i < 4; i++) begin
            tick();
            cmp_cnt++; if (data_out !== wdat[i]) begin err_cnt++; $display("FAIL wrap_rd_data[%0d]: got %h want %h", i, data_out, wdat[i]); end
            cmp_cnt++; if (data_out_valid !== 1'b1) begin err_cnt++; $display("FAIL wrap_rd_valid[%0d]: got %b want 1", i, data_out_valid); end
            cmp_cnt++; if (busy !== (i < 3)) begin err_cnt++; $display("FAIL wrap_rd_busy[%0d]: got %b want %b", i, busy, (i < 3)); end
        end
        cmp_cnt++; if (mar_out !== 8'h02) begin err_cnt++; $display("FAIL wrap_rd_mar: got %h want 02", mar_out); end
        tick();
        cmp_cnt++; if (data_out_valid !== 1'b0) begin err_cnt++; $display("FAIL wrap_rd_end: got %b want 0", data_out_valid); end
    endtask

    task automatic test_write_stalls();
        logic [15:0] wdat [4];
        logic [7:0]  mexp;
        wdat[0] = 16'hA0A0; wdat[1] = 16'hA1A1; wdat[2] = 16'hA2A2; wdat[3] = 16'hA3A3;
        address = 8'h10; set_address = 1'b1; set = 1'b1; burst_len = 3'd3;
        tick();
        idle_cmds();
        for (int i = 0; i < 4; i++) begin
            data_in = wdat[i]; data_in_valid = 1'b1;
            tick();
            if (i < 3) begin
                data_in = 16'hDEAD; data_in_valid = 1'b0;
                tick();
                mexp = 8'h11 + 8'(i);
                cmp_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL stall_busy[%0d]: got %b want 1", i, busy); end
                cmp_cnt++; if (mar_out !== mexp) begin err_cnt++; $display("FAIL stall_mar[%0d]: got %h want %h", i, mar_out, mexp); end
            end
        end
        data_in_valid = 1'b0;
        cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL stall_done: got %b want 0", busy); end
        cmp_cnt++; if (mar_out !== 8'h14) begin err_cnt++; $display("FAIL stall_mar_end: got %h want 14", mar_out); end
        address = 8'h10; set_address = 1'b1; enable = 1'b1; burst_len = 3'd3;
        tick();
        idle_cmds();
        for (int i = 0; i < 4; i++) begin
            tick();
            cmp_cnt++; if (data_out !== wdat[i]) begin err_cnt++; $display("FAIL stall_rd[%0d]: got %h want %h", i, data_out, wdat[i]); end
        end
    endtask

    task automatic test_illegal();
        set = 1'b1; enable = 1'b1; burst_len = 3'd2;
        tick();
        idle_cmds();
        cmp_cnt++; if (err !== 1'b1) begin err_cnt++; $display("FAIL ill_err: got %b want 1", err); end
        cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL ill_busy: got %b want 0", busy); end
        cmp_cnt++; if (mar_out !== 8'h14) begin err_cnt++; $display("FAIL ill_mar: got %h want 14", mar_out); end
        tick();
        cmp_cnt++; if (err !== 1'b0) begin err_cnt++; $display("FAIL ill_pulse: got %b want 0", err); end
        address = 8'h10; set_address = 1'b1; set = 1'b1; enable = 1'b1;
        tick();
        idle_cmds();
        cmp_cnt++; if (err !== 1'b1) begin err_cnt++; $display("FAIL ill_sa_err: got %b want 1", err); end
        cmp_cnt++; if (mar_out !== 8'h10) begin err_cnt++; $display("FAIL ill_sa_mar: got %h want 10", mar_out); end
        data_in = 16'hDEAD; data_in_valid = 1'b1;
        tick(); tick();
        data_in_valid = 1'b0;
        cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL ill_idle_busy: got %b want 0", busy); end
        cmp_cnt++; if (mar_out !== 8'h10) begin err_cnt++; $display("FAIL ill_idle_mar: got %h want 10", mar_out); end
        enable = 1'b1; burst_len = 3'd0;
        tick();
        idle_cmds();
        tick();
        cmp_cnt++; if (data_out !== 16'hA0A0) begin err_cnt++; $display("FAIL ill_mem: got %h want a0a0", data_out); end
        cmp_cnt++; if (mar_out !== 8'h11) begin err_cnt++; $display("FAIL ill_rd_mar: got %h want 11", mar_out); end
    endtask

    task automatic test_latency();
        b_address = 8'h20; b_set_address = 1'b1; b_set = 1'b1; b_burst_len = 3'd1;
        tick();
        idle_cmds();
        b_data_in = 16'hBEEF; b_data_in_valid = 1'b1;
        tick();
        b_data_in = 16'hCAFE;
        tick();
        b_data_in_valid = 1'b0;
        cmp_cnt++; if (b_busy !== 1'b0) begin err_cnt++; $display("FAIL lat_wr_busy: got %b want 0", b_busy); end
        b_address = 8'h20; b_set_address = 1'b1; b_enable = 1'b1; b_burst_len = 3'd1;
        tick();
        cmp_cnt++; if (b_busy !== 1'b1) begin err_cnt++; $display("FAIL lat_busy: got %b want 1", b_busy); end
        b_address = 8'h80; b_set_address = 1'b1; b_set = 1'b1; b_enable = 1'b1;
        tick();
        cmp_cnt++; if (b_data_out_valid !== 1'b0) begin err_cnt++; $display("FAIL lat_e1_valid: got %b want 0", b_data_out_valid); end
        cmp_cnt++; if (b_err !== 1'b0) begin err_cnt++; $display("FAIL lat_e1_err: got %b want 0", b_err); end
        tick();
        idle_cmds();
        cmp_cnt++; if (b_data_out_valid !== 1'b0) begin err_cnt++; $display("FAIL lat_e2_valid: got %b want 0", b_data_out_valid); end
        cmp_cnt++; if (b_busy !== 1'b1) begin err_cnt++; $display("FAIL lat_e2_busy: got %b want 1", b_busy); end
        cmp_cnt++; if (b_err !== 1'b0) begin err_cnt++; $display("FAIL lat_e2_err: got %b want 0", b_err); end
        tick();
        cmp_cnt++; if (b_data_out_valid !== 1'b1) begin err_cnt++; $display("FAIL lat_e3_valid: got %b want 1", b_data_out_valid); end
        cmp_cnt++; if (b_data_out !== 16'hBEEF) begin err_cnt++; $display("FAIL lat_e3_data: got %h want beef", b_data_out); end
        cmp_cnt++; if (b_busy !== 1'b1) begin err_cnt++; $display("FAIL lat_e3_busy: got %b want 1", b_busy); end
        tick();
        cmp_cnt++; if (b_data_out_valid !== 1'b1) begin err_cnt++; $display("FAIL lat_e4_valid: got %b want 1", b_data_out_valid); end
        cmp_cnt++; if (b_data_out !== 16'hCAFE) begin err_cnt++; $display("FAIL lat_e4_data: got %h want cafe", b_data_out); end
        cmp_cnt++; if (b_busy !== 1'b0) begin err_cnt++; $display("FAIL lat_e4_busy: got %b want 0", b_busy); end
        cmp_cnt++; if (b_mar_out !== 8'h22) begin err_cnt++; $display("FAIL lat_mar: got %h want 22", b_mar_out); end
        tick();
        cmp_cnt++; if (b_data_out_valid !== 1'b0) begin err_cnt++; $display("FAIL lat_e5_valid: got %b want 0", b_data_out_valid); end
        cmp_cnt++; if (b_data_out !== 16'hCAFE) begin err_cnt++; $display("FAIL lat_e5_hold: got %h want cafe", b_data_out); end
    endtask

    task automatic test_reset_mid_burst();
        logic [15:0] init [4];
        logic [15:0] rexp [4];
        init[0] = 16'h5555; init[1] = 16'h6666; init[2] = 16'h7777; init[3] = 16'h8888;
        rexp[0] = 16'h9001; rexp[1] = 16'h9002; rexp[2] = 16'h7777; rexp[3] = 16'h8888;
        address = 8'h40; set_address = 1'b1; set = 1'b1; burst_len = 3'd3;
        tick();
        idle_cmds();
        for (int i = 0; i < 4; i++) begin
            data_in = init[i]; data_in_valid = 1'b1;
            tick();
        end
        data_in_valid = 1'b0;
        address = 8'h40; set_address = 1'b1; set = 1'b1; burst_len = 3'd3;
        tick();
        idle_cmds();
        data_in = 16'h9001; data_in_valid = 1'b1;
        tick();
        data_in = 16'h9002;
        tick();
        data_in = 16'h9003;
        cmp_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL rmb_pre_busy: got %b want 1", busy); end
        cmp_cnt++; if (mar_out !== 8'h42) begin err_cnt++; $display("FAIL rmb_pre_mar: got %h want 42", mar_out); end
        #2 rst = 1'b1;
        #1;
        cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rmb_busy: got %b want 0", busy); end
        cmp_cnt++; if (mar_out !== 8'h00) begin err_cnt++; $display("FAIL rmb_mar: got %h want 00", mar_out); end
        cmp_cnt++; if (data_out !== 16'h0000) begin err_cnt++; $display("FAIL rmb_data: got %h want 0000", data_out); end
        cmp_cnt++; if (data_out_valid !== 1'b0) begin err_cnt++; $display("FAIL rmb_valid: got %b want 0", data_out_valid); end
        cmp_cnt++; if (err !== 1'b0) begin err_cnt++; $display("FAIL rmb_err: got %b want 0", err); end
        data_in_valid = 1'b0;
        #2 rst = 1'b0;
        tick();
        cmp_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rmb_post_busy: got %b want 0", busy); end
        address = 8'h40; set_address = 1'b1; enable = 1'b1; burst_len = 3'd3;
        tick();
        idle_cmds();
        for (int i = 0; i < 4; i++) begin
            tick();
            cmp_cnt++; if (data_out !== rexp[i]) begin err_cnt++; $display("FAIL rmb_rd[%0d]: got %h want %h", i, data_out, rexp[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_wrap();
        test_write_stalls();
        test_illegal();
        test_latency();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/ram_burst_controller.md
Name: ram_burst_controller

Overview:
Parametrised clocked successor to the project's MAR-addressed RAM, with the same set_address/set/enable command style. It adds a synchronous clock domain, multi-beat burst reads and writes with MAR auto-increment and wrap-around, and a configurable read pipeline latency. A busy/valid handshake lets the CPU control unit sequence memory traffic without fixed delays. It sits between the control unit/datapath bus and the memory array.

Parameters:
SIZE, 16, data word width in bits
MAR_SIZE, 8, address width; depth = 2**MAR_SIZE words
READ_LATENCY, 1, edges from read issue to data_out valid (legal values are 1 or more)
BL_W, 3, width of burst_len; beats per burst = burst_len+1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
address  in  MAR_SIZE  start address for set_address
set_address  in  1  load MAR from address (IDLE only)
set  in  1  start write burst (IDLE only)
enable  in  1  start read burst (IDLE only)
burst_len  in  BL_W  beats minus one, sampled at command accept
data_in  in  SIZE  write data
data_in_valid  in  1  write beat present this cycle
data_out  out  SIZE  read data, holds last value when not valid
data_out_valid  out  1  one-cycle strobe per read beat
busy  out  1  burst in progress; commands ignored
err  out  1  one-cycle pulse on illegal command
mar_out  out  MAR_SIZE  current MAR value

Behaviour:
- Reset (async, any state): state=IDLE; MAR=0; data_out=0; data_out_valid=0; busy=0; err=0; the read pipeline is flushed. Memory contents are not cleared.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE, set_address=1: MAR<=address. If set or enable is high in the same cycle, the burst starts at address, not at the old MAR.
- IDLE, set=1 and enable=0: beats<=burst_len+1, go to WRITE, busy=1 from the next cycle.
- IDLE, enable=1 and set=0: beats<=burst_len+1, go to READ, busy=1 from the next cycle.
- IDLE, set=1 and enable=1: no operation, MAR unchanged (set_address still applies), err=1 for exactly one cycle.
- WRITE: each edge with data_in_valid=1 does mem[MAR]<=data_in, MAR<=MAR+1 (mod 2**MAR_SIZE), beats decrements. Cycles with data_in_valid=0 stall with no change. The edge that writes the last beat returns to IDLE; busy=0 from the next cycle.
- READ: each edge issues a read of mem[MAR], MAR increments and wraps. There are no stalls. After the last issue go to DRAIN.
- Read data timing: data for an issue at edge E appears on data_out with data_out_valid=1 at edge E+READ_LATENCY-1. With READ_LATENCY=1 the data is registered at the issue edge itself. Beats are back-to-back, in address order.
- DRAIN: wait until the final beat is presented, then go to IDLE. busy deasserts on the same edge that presents the final data_out_valid, so the last valid beat and busy=0 are seen in the same cycle.
- Commands (set, enable, set_address) while busy=1 are ignored and do not raise err.
- MAR after a burst equals start + beats (mod 2**MAR_SIZE), so a following burst continues sequentially.
- Read-after-write to the same address returns the newly written data; no bypass is needed because a read cannot start until the write burst completes.
- Reset mid-burst aborts immediately. Partial writes already committed remain in memory; no further data_out_valid is produced.

Test Plan:
- Single beat: set_address, address=0; set with burst_len=0; data_in=16'hABCD, data_in_valid=1; then enable with burst_len=0 at address 0 -> data_out=16'hABCD, data_out_valid high for one cycle, mar_out=1 afterwards.
- Wrap burst: address=8'hFE, set, burst_len=3, data 16'h1111/2222/3333/4444 -> written to FE,FF,00,01; mar_out=8'h02. A read burst from FE returns the same four values in order on consecutive cycles.
- Write stalls: the same 4-beat write with data_in_valid low on alternate cycles -> exactly 4 words written, busy held high throughout, no extra MAR increments.
- Latency: READ_LATENCY=3, 2-beat read -> first data_out_valid 2 edges after the first issue edge; busy falls on the edge presenting the second beat; set/enable pulsed during busy are ignored.
- Illegal command: set=1 and enable=1 together in IDLE -> err pulses for one cycle, busy stays 0, memory and MAR unchanged.
- Reset mid-burst: assert rst asynchronously after 2 of 4 write beats -> all outputs go to their reset values immediately; a later read shows beats 0-1 written and beats 2-3 unchanged.
